// File: rtl/des_fp_serializer.sv
// DES output stage: half swap + final permutation IP^-1 into a held block register,
// then streamed out as 8 bytes over a valid/ready handshake.
module des_fp_serializer #(
    parameter bit SWAP_EN   = 1'b1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] l16,
    input  logic [31:0] r16,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic [63:0] block_out,
    output logic        busy
);

    localparam int unsigned BLK_W  = 64;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0]   block_d;
    logic [BLK_W-1:0]   pre;
    logic [BLK_W-1:0]   fp;
    logic               in_ready_d, out_valid_d, out_last_d, busy_d;
    logic [BYTE_W-1:0]  out_byte_d;

    assign pre = SWAP_EN ? {r16, l16} : {l16, r16};

    // IP^-1: DES output bit k+1 takes preoutput bit T = base(col) - row, base = 40,8,48,16,56,24,64,32
    for (genvar k = 0; k < 64; k++) begin : g_fp
        localparam int unsigned COL = k % 8;
        localparam int unsigned ROW = k / 8;
        localparam int unsigned T   = ((COL % 2) == 0) ? (40 + 4 * COL - ROW) : (4 * COL + 4 - ROW);
        assign fp[63-k] = pre[64-T];
    end

    function automatic logic [BYTE_W-1:0] sel_byte(input logic [BLK_W-1:0] blk,
                                                  input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] idx;
        idx = MSB_FIRST ? CNT_W'(3'd7 - c) : c;
        return blk[{idx, 3'b000} +: BYTE_W];
    endfunction

    // Next state plus next values of every registered output
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        block_d = block_out;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    block_d = fp;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d == SEND);
        out_last_d  = (state_d == SEND) && (cnt_d == CNT_W'(7));
        out_byte_d  = (state_d == SEND) ? sel_byte(block_d, cnt_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            block_out <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_byte  <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            block_out <= block_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_byte  <= out_byte_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_des_fp_serializer.sv
// Directed bench for des_fp_serializer: default build plus a no-swap, LSB-first build
// driven from the same stimulus.
module tb_des_fp_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] l16, r16;
    logic        out_ready;

    logic        in_ready, out_valid, out_last, busy;
    logic [7:0]  out_byte;
    logic [63:0] block_out;
    logic        b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [7:0]  b_out_byte;
    logic [63:0] b_block_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    des_fp_serializer #(.SWAP_EN(1'b1), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .l16(l16), .r16(r16), .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last), .block_out(block_out), .busy(busy)
    );

    des_fp_serializer #(.SWAP_EN(1'b0), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .l16(l16), .r16(r16), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_byte(b_out_byte), .out_last(b_out_last), .block_out(b_block_out), .busy(b_busy)
    );

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [63:0] exp_a;   // FP({r,l})
        logic [63:0] exp_b;   // FP({l,r})
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [63:0] v, input int i, input bit msb);
        return msb ? v[8*(7-i) +: 8] : v[8*i +: 8];
    endfunction

    // Send one block with out_ready high and check both builds byte by byte
    task automatic run_vec(input int idx);
        logic [63:0] got_a, got_b;
        @(negedge clk);
        l16 = vecs[idx].l; r16 = vecs[idx].r; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d in_ready_low", idx), 64'(in_ready), 64'd0);
        chk($sformatf("v%0d block_a", idx), block_out, vecs[idx].exp_a);
        chk($sformatf("v%0d block_b", idx), b_block_out, vecs[idx].exp_b);
        got_a = '0; got_b = '0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("v%0d valid_last[%0d]", idx, i), {62'd0, out_valid, out_last},
                {62'd0, 1'b1, (i == 7)});
            got_a = {got_a[55:0], out_byte};
            got_b = {got_b[55:0], b_out_byte};
            @(negedge clk);
        end
        chk($sformatf("v%0d bytes_a", idx), got_a, vecs[idx].exp_a);
        chk($sformatf("v%0d bytes_b", idx), got_b,
            {byte_of(vecs[idx].exp_b, 0, 1'b0), byte_of(vecs[idx].exp_b, 1, 1'b0),
             byte_of(vecs[idx].exp_b, 2, 1'b0), byte_of(vecs[idx].exp_b, 3, 1'b0),
             byte_of(vecs[idx].exp_b, 4, 1'b0), byte_of(vecs[idx].exp_b, 5, 1'b0),
             byte_of(vecs[idx].exp_b, 6, 1'b0), byte_of(vecs[idx].exp_b, 7, 1'b0)});
        chk($sformatf("v%0d idle_after", idx), {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("drain_timeout", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] got;
        logic [7:0]  held;
        logic        stalled;
        int          hs, cyc;

        vecs[0] = '{32'h43423234, 32'h0A4CD995, 64'h85E813540F0AB405, 64'h4AD423A80F05780A};
        vecs[1] = '{32'h80000000, 32'h00000000, 64'h0000000000000080, 64'h0000000000000040};
        vecs[2] = '{32'h00000000, 32'h00000001, 64'h0100000000000000, 64'h0200000000000000};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        vecs[4] = '{32'h00000000, 32'h00000000, 64'h0000000000000000, 64'h0000000000000000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; l16 = '0; r16 = '0;
        repeat (2) @(negedge clk);
        chk("reset_flags", {59'd0, in_ready, out_valid, out_last, busy, b_in_ready},
            {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        chk("reset_block", block_out, 64'd0);
        chk("reset_byte", 64'(out_byte), 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) run_vec(v);

        // Backpressure: out_ready pattern 1,0,0,1 repeating
        @(negedge clk);
        l16 = vecs[0].l; r16 = vecs[0].r; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        got = '0; hs = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (hs < 8 && cyc < 64) begin
            if (stalled) chk($sformatf("bp stable c%0d", cyc), 64'(out_byte), 64'(held));
            chk($sformatf("bp busy c%0d", cyc), {62'd0, out_valid, in_ready}, {62'd0, 1'b1, 1'b0});
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (out_valid && out_ready) begin
                got = {got[55:0], out_byte};
                hs++;
                stalled = 1'b0;
            end else begin
                held = out_byte;
                stalled = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        chk("bp handshakes", 64'(hs), 64'd8);
        chk("bp bytes", got, 64'h85E813540F0AB405);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp no_extra[%0d]", i), {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
            @(negedge clk);
        end

        // Back-to-back: in_valid held across two blocks
        l16 = vecs[0].l; r16 = vecs[0].r; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        l16 = vecs[1].l; r16 = vecs[1].r;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b2b A byte%0d", i), 64'(out_byte), 64'(byte_of(vecs[0].exp_a, i, 1'b1)));
            @(negedge clk);
        end
        chk("b2b gap in_ready", 64'(in_ready), 64'd1);
        chk("b2b A kept", block_out, vecs[0].exp_a);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b B loaded", block_out, vecs[1].exp_a);
        chk("b2b B byte0", {55'd0, busy, out_byte}, {55'd0, 1'b1, byte_of(vecs[1].exp_a, 0, 1'b1)});
        drain();

        // Reset during SEND after byte 3 has been taken
        @(negedge clk);
        l16 = vecs[0].l; r16 = vecs[0].r; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst pre byte4", 64'(out_byte), 64'h0F);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst flags", {59'd0, out_valid, in_ready, busy, out_last, b_out_valid},
            {59'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("rst block", block_out, 64'd0);
        chk("rst byte", 64'(out_byte), 64'd0);
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
